// File: rtl/injector_pkg.sv
// Shared types and constants for the traffic injector slice:
// FSM state enum, header tag, router port codes and the LFSR tap mask.
package injector_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_CREDIT,
    HEADER,
    BODY,
    DONE
  } state_e;

  localparam logic [1:0] HDR_TAG = 2'b10;

  localparam logic [2:0] PE    = 3'd0;
  localparam logic [2:0] X_POS = 3'd1;
  localparam logic [2:0] X_NEG = 3'd2;
  localparam logic [2:0] Y_POS = 3'd3;
  localparam logic [2:0] Y_NEG = 3'd4;

  // Taps 16,14,13,11 expressed as bit positions of a right-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, steps once per cycle while advance is high.
// Ports: clk, reset (async, high), advance, seed (reset value), value.
module lfsr16
  import injector_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic        fb;

  assign fb    = ^(value_q & LFSR_TAPS);
  assign value = value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= seed;
    end else if (advance) begin
      value_q <= {fb, value_q[15:1]};
    end
  end

endmodule

// File: rtl/traffic_injector.sv
// Credit-flow packet generator for one router input channel.
// Ports: clk, reset, start, num_packets, credit_in -> valid_out, flit_out,
// busy, done, sent_count, credit_err. Option: TRAFFIC_INJECTOR_GAP_EN.
module traffic_injector
  import injector_pkg::*;
#(
  parameter int          FLIT_W       = 32,
  parameter int          PACKET_FLITS = 5,
  parameter int          X_W          = 3,
  parameter int          Y_W          = 3,
  parameter int          X_LOCAL      = 2,
  parameter int          Y_LOCAL      = 2,
  parameter int          PE_PERCENT   = 0,
  parameter int          CREDITS      = 4,
  parameter int          CNT_W        = 16,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_packets,
  input  logic              credit_in,
  output logic              valid_out,
  output logic [FLIT_W-1:0] flit_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_count,
  output logic              credit_err
);

  localparam int CRW       = $clog2(CREDITS + 1);
  localparam int HW        = FLIT_W - 2 - X_W - Y_W;
  localparam int IDX_W     = FLIT_W - 8;
  localparam int PE_THRESH = (PE_PERCENT * 128) / 100;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [CRW-1:0]     cred_q, cred_d;
  logic               err_q, err_d;
  logic [7:0]         k_q, k_d;
  logic               valid_q, valid_d;
  logic [FLIT_W-1:0]  flit_q, flit_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [15:0]        lfsr_v;
  logic               hdr_go;
  logic               gap_ok;
  logic               last_pkt;
  logic               consume;
  logic [X_W-1:0]     dst_x;
  logic [Y_W-1:0]     dst_y;
  logic               unused_lfsr;

  assign unused_lfsr = ^lfsr_v;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (hdr_go),
    .seed    (SEED),
    .value   (lfsr_v)
  );

`ifdef TRAFFIC_INJECTOR_GAP_EN
  logic [1:0] gap_q, gap_d;

  assign gap_ok = (gap_q == 2'd0);

  // Gap length is sampled as WAIT_CREDIT is entered, then counts
  // down alongside the credit wait.
  always_comb begin
    gap_d = gap_q;
    if (state_q != WAIT_CREDIT && state_d == WAIT_CREDIT) begin
      gap_d = lfsr_v[1:0];
    end else if (state_q == WAIT_CREDIT && gap_q != 2'd0) begin
      gap_d = gap_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gap_q <= 2'd0;
    else       gap_q <= gap_d;
  end
`else
  assign gap_ok = 1'b1;
`endif

  always_comb begin
    dst_x = X_W'(X_LOCAL);
    dst_y = Y_W'(Y_LOCAL);
    if ({25'd0, lfsr_v[6:0]} >= PE_THRESH) begin
      dst_x = lfsr_v[7 +: X_W];
      dst_y = lfsr_v[10 +: Y_W];
      // A random pick of the local router is steered one hop east.
      if (dst_x == X_W'(X_LOCAL) && dst_y == Y_W'(Y_LOCAL)) begin
        dst_x = X_W'(X_LOCAL + 1);
      end
    end
  end

  assign last_pkt = ({1'b0, sent_q} + 1'b1) == {1'b0, num_q};
  assign consume  = (state_q == HEADER);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    sent_d  = sent_q;
    k_d     = k_q;
    hdr_go  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ARM;
          num_d   = num_packets;
          sent_d  = '0;
        end
      end
      ARM: begin
        state_d = (num_q == '0) ? DONE : WAIT_CREDIT;
      end
      WAIT_CREDIT: begin
        if (cred_q != '0 && gap_ok) begin
          state_d = HEADER;
          hdr_go  = 1'b1;
        end
      end
      HEADER: begin
        state_d = BODY;
        k_d     = 8'd1;
      end
      BODY: begin
        if (k_q == 8'(PACKET_FLITS - 1)) begin
          state_d = last_pkt ? DONE : WAIT_CREDIT;
          if (sent_q != '1) sent_d = sent_q + 1'b1;
        end else begin
          k_d = k_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    valid_d = 1'b0;
    flit_d  = '0;
    busy_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = (state_d == DONE);
    if (state_d == HEADER) begin
      valid_d = 1'b1;
      flit_d  = {HDR_TAG, dst_x, dst_y, HW'(sent_q)};
    end else if (state_d == BODY) begin
      valid_d = 1'b1;
      flit_d  = {k_d, IDX_W'(sent_q)};
    end
  end

  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    if (consume && !credit_in) begin
      cred_d = cred_q - 1'b1;
    end else if (!consume && credit_in) begin
      if (cred_q == CRW'(CREDITS)) err_d = 1'b1;
      else                         cred_d = cred_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      sent_q  <= '0;
      cred_q  <= CRW'(CREDITS);
      err_q   <= 1'b0;
      k_q     <= '0;
      valid_q <= 1'b0;
      flit_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      sent_q  <= sent_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      flit_q  <= flit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign valid_out  = valid_q;
  assign flit_out   = flit_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = sent_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_traffic_injector.sv
// Directed bench for traffic_injector with a flit scoreboard.
// Expected flits come from a bench-side LFSR and destination model.
module tb_traffic_injector;

  localparam int          FW   = 32;
  localparam int          PF   = 5;
  localparam int          CW   = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_packets;
  logic          credit_in;
  logic          valid_out;
  logic [FW-1:0] flit_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_count;
  logic          credit_err;

  int            errors = 0;
  int            checks = 0;
  logic [FW-1:0] exp_q[$];
  logic [15:0]   m_lfsr;
  bit            auto_credit;
  int            cyc, nflits, first_cyc, last_cyc, done_cyc;

  always #5 clk = ~clk;

  traffic_injector #(.PE_PERCENT(50)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_packets (num_packets),
    .credit_in   (credit_in),
    .valid_out   (valid_out),
    .flit_out    (flit_out),
    .busy        (busy),
    .done        (done),
    .sent_count  (sent_count),
    .credit_err  (credit_err)
  );

  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // 50 percent PE share: threshold 64 on lfsr[6:0].
  function automatic logic [FW-1:0] hdr(logic [15:0] v, int idx);
    logic [2:0] x, y;
    if (v[6:0] < 7'd64) begin
      x = 3'd2;
      y = 3'd2;
    end else begin
      x = v[9:7];
      y = v[12:10];
      if (x == 3'd2 && y == 3'd2) x = 3'd3;
    end
    return {2'b10, x, y, 24'(idx)};
  endfunction

  task automatic push_run(int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(hdr(m_lfsr, i));
      m_lfsr = lfsr_next(m_lfsr);
      for (int k = 1; k < PF; k++) exp_q.push_back({8'(k), 24'(i)});
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    credit_in = auto_credit && valid_out && (flit_out[FW-1 -: 2] == 2'b10);
    if (valid_out) begin
      nflits++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      chk("flit_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("flit", flit_out, exp_q.pop_front());
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic do_start(int n);
    num_packets = CW'(n);
    start       = 1'b1;
    cyc         = 0;
    nflits      = 0;
    first_cyc   = -1;
    last_cyc    = -1;
    done_cyc    = -1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_done(int budget);
    while (!done && cyc < budget) cycle();
    chk("done_in_budget", 32'(done), 32'd1);
  endtask

  task automatic pulse_credit();
    credit_in = 1'b1;
    cycle();
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    num_packets = '0;
    credit_in   = 1'b0;
    auto_credit = 1'b0;
    m_lfsr      = SEED;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_flit", flit_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sent", 32'(sent_count), 32'd0);
    chk("rst_err", 32'(credit_err), 32'd0);
    reset = 1'b0;
    cycle();

    // Three packets with credits returned alongside each header.
    auto_credit = 1'b1;
    push_run(3);
    do_start(3);
    chk("arm_busy", 32'(busy), 32'd1);
    run_until_done(100);
    chk("a_first_hdr_cyc", 32'(first_cyc), 32'd3);
    chk("a_flits", 32'(nflits), 32'd15);
    chk("a_done_cyc", 32'(done_cyc), 32'(3 + 3 * PF + 2));
    chk("a_done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
    chk("a_sent", 32'(sent_count), 32'd3);
    chk("a_busy_off", 32'(busy), 32'd0);
    chk("a_no_err", 32'(credit_err), 32'd0);
    chk("a_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length run.
    do_start(0);
    chk("z_done_cleared", 32'(done), 32'd0);
    cycle();
    chk("z_done_cyc2", 32'(done), 32'd1);
    chk("z_no_flits", 32'(nflits), 32'd0);
    chk("z_sent", 32'(sent_count), 32'd0);

    // Longer run mixing PE-bound and random destinations.
    push_run(40);
    do_start(40);
    run_until_done(40 * (PF + 1) + 20);
    chk("l_flits", 32'(nflits), 32'(40 * PF));
    chk("l_sent", 32'(sent_count), 32'd40);
    chk("l_queue_empty", 32'(exp_q.size()), 32'd0);

    // Credit exhaustion: only CREDITS packets go without returns.
    auto_credit = 1'b0;
    push_run(6);
    do_start(6);
    repeat (60) cycle();
    chk("s_sent_stall", 32'(sent_count), 32'd4);
    chk("s_flits_stall", 32'(nflits), 32'(4 * PF));
    chk("s_busy_stall", 32'(busy), 32'd1);
    chk("s_not_done", 32'(done), 32'd0);
    pulse_credit();
    pulse_credit();
    run_until_done(200);
    chk("s_sent_final", 32'(sent_count), 32'd6);
    chk("s_flits_final", 32'(nflits), 32'(6 * PF));
    chk("s_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (4) pulse_credit();
    cycle();
    chk("s_refill_no_err", 32'(credit_err), 32'd0);
    pulse_credit();
    chk("s_overflow_err", 32'(credit_err), 32'd1);
    repeat (3) cycle();
    chk("s_err_sticky", 32'(credit_err), 32'd1);

    // Overflow must not have raised the count above CREDITS.
    push_run(5);
    do_start(5);
    repeat (60) cycle();
    chk("o_sent_stall", 32'(sent_count), 32'd4);
    chk("o_err_still", 32'(credit_err), 32'd1);

    reset = 1'b1;
    #1;
    chk("r1_busy", 32'(busy), 32'd0);
    chk("r1_err_clr", 32'(credit_err), 32'd0);
    exp_q.delete();
    m_lfsr = SEED;
    cycle();
    reset = 1'b0;

    // Reset during flit 3 of packet 2.
    auto_credit = 1'b1;
    push_run(3);
    do_start(3);
    while (nflits < PF + 3 && cyc < 100) cycle();
    chk("m_reached_flit", 32'(nflits), 32'(PF + 3));
    chk("m_valid_before", 32'(valid_out), 32'd1);
    chk("m_sent_before", 32'(sent_count), 32'd1);
    reset = 1'b1;
    #1;
    chk("m_valid_clr", 32'(valid_out), 32'd0);
    chk("m_sent_clr", 32'(sent_count), 32'd0);
    chk("m_flit_clr", flit_out, 32'd0);
    exp_q.delete();
    m_lfsr = SEED;
    cycle();
    reset = 1'b0;
    cycle();
    push_run(1);
    do_start(1);
    run_until_done(50);
    chk("m_restart_flits", 32'(nflits), 32'(PF));
    chk("m_restart_sent", 32'(sent_count), 32'd1);
    chk("m_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
